// File: rtl/uart_rx_pkg.sv
// Shared types and constants for the UART RX frame checker.
package uart_rx_pkg;

  // FSM state encoding
  typedef logic [2:0] state_t;
  localparam state_t ST_IDLE   = 3'd0;
  localparam state_t ST_START  = 3'd1;
  localparam state_t ST_DATA   = 3'd2;
  localparam state_t ST_PARITY = 3'd3;
  localparam state_t ST_STOP   = 3'd4;

  // Parity type encoding for par_typ
  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

endpackage

// File: rtl/uart_rx_frame_checker_if.sv
// Sampled-bit stream, frame configuration and status bundle of the frame checker.
interface uart_rx_frame_checker_if #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ERR_CNT_W  = 8
) ();
  import uart_rx_pkg::*;

  logic                  frame_begin;
  logic                  bit_valid;
  logic                  sampled_bit;
  logic                  par_en;
  logic                  par_typ;
  logic                  two_stop;
  logic                  clr_cnt;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  data_valid;
  logic                  strt_glitch;
  logic                  par_err;
  logic                  stp_err;
  logic                  busy;
  logic [ERR_CNT_W-1:0]  glitch_cnt;
  logic [ERR_CNT_W-1:0]  par_err_cnt;
  logic [ERR_CNT_W-1:0]  stp_err_cnt;

  // Upstream sampler / register file side
  modport master (
    output frame_begin, bit_valid, sampled_bit, par_en, par_typ, two_stop, clr_cnt,
    input  data_out, data_valid, strt_glitch, par_err, stp_err, busy,
    input  glitch_cnt, par_err_cnt, stp_err_cnt
  );

  // Frame checker side
  modport slave (
    input  frame_begin, bit_valid, sampled_bit, par_en, par_typ, two_stop, clr_cnt,
    output data_out, data_valid, strt_glitch, par_err, stp_err, busy,
    output glitch_cnt, par_err_cnt, stp_err_cnt
  );
endinterface

// File: rtl/rx_err_counter.sv
// Saturating error counter; a clear wins over a same-cycle increment.
module rx_err_counter #(
  parameter int unsigned ERR_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 inc,
  input  logic                 clr,
  output logic [ERR_CNT_W-1:0] cnt
);

  // Count up to all-ones and hold there
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != {ERR_CNT_W{1'b1}})) begin
      cnt <= cnt + ERR_CNT_W'(1);
    end
  end

endmodule

// File: rtl/uart_rx_frame_checker.sv
// UART RX frame checker: start-glitch, parity and stop checks plus LSB-first deserialiser.
module uart_rx_frame_checker
  import uart_rx_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ERR_CNT_W  = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  uart_rx_frame_checker_if.slave  bus
);

  localparam int unsigned CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  state_t                state, state_nxt;
  logic [DATA_WIDTH-1:0] shift_reg, shift_nxt;
  logic [CNT_W-1:0]      bit_cnt, bit_cnt_nxt;
  logic                  stop_cnt, stop_cnt_nxt;
  logic                  cfg_par_en, cfg_par_en_nxt;
  logic                  cfg_par_typ, cfg_par_typ_nxt;
  logic                  cfg_two_stop, cfg_two_stop_nxt;
  logic                  run_par, run_par_nxt;
  logic                  par_flag, par_flag_nxt;
  logic                  stp_flag, stp_flag_nxt;
  logic [DATA_WIDTH-1:0] data_out, data_out_nxt;
  logic                  data_valid, data_valid_nxt;
  logic                  strt_glitch, strt_glitch_nxt;
  logic                  par_err, par_err_nxt;
  logic                  stp_err, stp_err_nxt;
  logic                  busy;
  logic                  glitch_inc_c, par_inc_c, stp_inc_c;
  logic                  exp_par_c, stp_flag_c;

  // State, datapath and registered outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= ST_IDLE;
      shift_reg    <= '0;
      bit_cnt      <= '0;
      stop_cnt     <= 1'b0;
      cfg_par_en   <= 1'b0;
      cfg_par_typ  <= 1'b0;
      cfg_two_stop <= 1'b0;
      run_par      <= 1'b0;
      par_flag     <= 1'b0;
      stp_flag     <= 1'b0;
      data_out     <= '0;
      data_valid   <= 1'b0;
      strt_glitch  <= 1'b0;
      par_err      <= 1'b0;
      stp_err      <= 1'b0;
      busy         <= 1'b0;
    end else begin
      state        <= state_nxt;
      shift_reg    <= shift_nxt;
      bit_cnt      <= bit_cnt_nxt;
      stop_cnt     <= stop_cnt_nxt;
      cfg_par_en   <= cfg_par_en_nxt;
      cfg_par_typ  <= cfg_par_typ_nxt;
      cfg_two_stop <= cfg_two_stop_nxt;
      run_par      <= run_par_nxt;
      par_flag     <= par_flag_nxt;
      stp_flag     <= stp_flag_nxt;
      data_out     <= data_out_nxt;
      data_valid   <= data_valid_nxt;
      strt_glitch  <= strt_glitch_nxt;
      par_err      <= par_err_nxt;
      stp_err      <= stp_err_nxt;
      busy         <= (state_nxt != ST_IDLE);
    end
  end

  // Next-state, datapath update and completion pulses
  always_comb begin
    state_nxt        = state;
    shift_nxt        = shift_reg;
    bit_cnt_nxt      = bit_cnt;
    stop_cnt_nxt     = stop_cnt;
    cfg_par_en_nxt   = cfg_par_en;
    cfg_par_typ_nxt  = cfg_par_typ;
    cfg_two_stop_nxt = cfg_two_stop;
    run_par_nxt      = run_par;
    par_flag_nxt     = par_flag;
    stp_flag_nxt     = stp_flag;
    data_out_nxt     = data_out;
    data_valid_nxt   = 1'b0;
    strt_glitch_nxt  = 1'b0;
    par_err_nxt      = 1'b0;
    stp_err_nxt      = 1'b0;
    glitch_inc_c     = 1'b0;
    par_inc_c        = 1'b0;
    stp_inc_c        = 1'b0;
    exp_par_c        = (cfg_par_typ == PAR_ODD) ? ~run_par : run_par;
    stp_flag_c       = stp_flag | ~bus.sampled_bit;

    case (state)
      ST_IDLE: begin
        // A coincident bit_valid is deliberately dropped here
        if (bus.frame_begin) begin
          cfg_par_en_nxt   = bus.par_en;
          cfg_par_typ_nxt  = bus.par_typ;
          cfg_two_stop_nxt = bus.two_stop;
          run_par_nxt      = 1'b0;
          par_flag_nxt     = 1'b0;
          stp_flag_nxt     = 1'b0;
          state_nxt        = ST_START;
        end
      end

      ST_START: begin
        if (bus.bit_valid) begin
          if (!bus.sampled_bit) begin
            bit_cnt_nxt = '0;
            state_nxt   = ST_DATA;
          end else begin
            strt_glitch_nxt = 1'b1;
            glitch_inc_c    = 1'b1;
            state_nxt       = ST_IDLE;
          end
        end
      end

      ST_DATA: begin
        if (bus.bit_valid) begin
          shift_nxt   = {bus.sampled_bit, shift_reg[DATA_WIDTH-1:1]};
          run_par_nxt = run_par ^ bus.sampled_bit;
          bit_cnt_nxt = bit_cnt + CNT_W'(1);
          if (bit_cnt == CNT_W'(DATA_WIDTH - 1)) begin
            stop_cnt_nxt = 1'b0;
            state_nxt    = cfg_par_en ? ST_PARITY : ST_STOP;
          end
        end
      end

      ST_PARITY: begin
        if (bus.bit_valid) begin
          if (bus.sampled_bit != exp_par_c) begin
            par_flag_nxt = 1'b1;
          end
          stop_cnt_nxt = 1'b0;
          state_nxt    = ST_STOP;
        end
      end

      ST_STOP: begin
        if (bus.bit_valid) begin
          stp_flag_nxt = stp_flag_c;
          if (cfg_two_stop && !stop_cnt) begin
            stop_cnt_nxt = 1'b1;
          end else begin
            par_err_nxt = par_flag;
            stp_err_nxt = stp_flag_c;
            par_inc_c   = par_flag;
            stp_inc_c   = stp_flag_c;
            if (!par_flag && !stp_flag_c) begin
              data_out_nxt   = shift_reg;
              data_valid_nxt = 1'b1;
            end
            state_nxt = ST_IDLE;
          end
        end
      end

      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // Per-class saturating error counters
  rx_err_counter #(.ERR_CNT_W(ERR_CNT_W)) u_glitch_cnt (
    .clk (clk),
    .rst (rst),
    .inc (glitch_inc_c),
    .clr (bus.clr_cnt),
    .cnt (bus.glitch_cnt)
  );

  rx_err_counter #(.ERR_CNT_W(ERR_CNT_W)) u_par_err_cnt (
    .clk (clk),
    .rst (rst),
    .inc (par_inc_c),
    .clr (bus.clr_cnt),
    .cnt (bus.par_err_cnt)
  );

  rx_err_counter #(.ERR_CNT_W(ERR_CNT_W)) u_stp_err_cnt (
    .clk (clk),
    .rst (rst),
    .inc (stp_inc_c),
    .clr (bus.clr_cnt),
    .cnt (bus.stp_err_cnt)
  );

  // Drive registered outputs onto the bundle
  assign bus.data_out    = data_out;
  assign bus.data_valid  = data_valid;
  assign bus.strt_glitch = strt_glitch;
  assign bus.par_err     = par_err;
  assign bus.stp_err     = stp_err;
  assign bus.busy        = busy;

endmodule

// File: tb/tb_uart_rx_frame_checker.sv
// Directed self-checking bench for uart_rx_frame_checker (DATA_WIDTH=8, ERR_CNT_W=2).
module tb_uart_rx_frame_checker;

  localparam int unsigned DW = 8;
  localparam int unsigned CW = 2;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  uart_rx_frame_checker_if #(.DATA_WIDTH(DW), .ERR_CNT_W(CW)) bus ();

  uart_rx_frame_checker #(.DATA_WIDTH(DW), .ERR_CNT_W(CW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", tag, act, exp);
    end
  endtask

  // One bit_valid strobe; returns on the falling edge after the consuming rising edge
  task automatic send_bit(input logic b, input logic clr);
    @(negedge clk);
    bus.bit_valid   = 1'b1;
    bus.sampled_bit = b;
    bus.clr_cnt     = clr;
    @(negedge clk);
    bus.bit_valid   = 1'b0;
    bus.clr_cnt     = 1'b0;
  endtask

  task automatic begin_frame(input logic pe, input logic pt, input logic ts);
    @(negedge clk);
    bus.par_en      = pe;
    bus.par_typ     = pt;
    bus.two_stop    = ts;
    bus.frame_begin = 1'b1;
    @(negedge clk);
    bus.frame_begin = 1'b0;
    // Config changes mid-frame must not matter
    bus.par_en      = ~pe;
    bus.par_typ     = ~pt;
    bus.two_stop    = ~ts;
  endtask

  // Full frame; returns right after the last stop bit so completion pulses are visible
  task automatic send_frame(input logic [7:0] d, input logic pe, input logic pt, input logic pb,
                            input logic ts, input logic s1, input logic s2);
    begin_frame(pe, pt, ts);
    send_bit(1'b0, 1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i], 1'b0);
    if (pe) send_bit(pb, 1'b0);
    send_bit(s1, 1'b0);
    if (ts) send_bit(s2, 1'b0);
  endtask

  task automatic check_idle_zero(input string tag);
    check({tag, "_data_out"},    32'(bus.data_out),    32'h0);
    check({tag, "_data_valid"},  32'(bus.data_valid),  32'h0);
    check({tag, "_strt_glitch"}, 32'(bus.strt_glitch), 32'h0);
    check({tag, "_par_err"},     32'(bus.par_err),     32'h0);
    check({tag, "_stp_err"},     32'(bus.stp_err),     32'h0);
    check({tag, "_busy"},        32'(bus.busy),        32'h0);
    check({tag, "_glitch_cnt"},  32'(bus.glitch_cnt),  32'h0);
    check({tag, "_par_cnt"},     32'(bus.par_err_cnt), 32'h0);
    check({tag, "_stp_cnt"},     32'(bus.stp_err_cnt), 32'h0);
  endtask

  logic [7:0] d5a;

  initial begin
    n_checks        = 0;
    n_fail          = 0;
    rst             = 1'b0;
    bus.frame_begin = 1'b0;
    bus.bit_valid   = 1'b0;
    bus.sampled_bit = 1'b1;
    bus.par_en      = 1'b0;
    bus.par_typ     = 1'b0;
    bus.two_stop    = 1'b0;
    bus.clr_cnt     = 1'b0;
    d5a             = 8'h5A;
    repeat (3) @(negedge clk);
    check_idle_zero("reset");
    rst = 1'b1;

    // Clean even-parity frame 0xA5
    send_frame(8'hA5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    check("a5_valid",    32'(bus.data_valid),  32'h1);
    check("a5_data",     32'(bus.data_out),    32'hA5);
    check("a5_par_err",  32'(bus.par_err),     32'h0);
    check("a5_stp_err",  32'(bus.stp_err),     32'h0);
    check("a5_busy",     32'(bus.busy),        32'h0);
    check("a5_gcnt",     32'(bus.glitch_cnt),  32'h0);
    check("a5_pcnt",     32'(bus.par_err_cnt), 32'h0);
    check("a5_scnt",     32'(bus.stp_err_cnt), 32'h0);
    @(negedge clk);
    check("a5_valid_pulse", 32'(bus.data_valid), 32'h0);

    // Start glitch, then stray strobes while idle
    begin_frame(1'b0, 1'b0, 1'b0);
    check("gl_busy_hi", 32'(bus.busy), 32'h1);
    send_bit(1'b1, 1'b0);
    check("gl_pulse",   32'(bus.strt_glitch), 32'h1);
    check("gl_cnt",     32'(bus.glitch_cnt),  32'h1);
    check("gl_busy_lo", 32'(bus.busy),        32'h0);
    for (int i = 0; i < 8; i++) begin
      send_bit(i[0], 1'b0);
      check("stray_busy",  32'(bus.busy),        32'h0);
      check("stray_valid", 32'(bus.data_valid),  32'h0);
      check("stray_glitch", 32'(bus.strt_glitch), 32'h0);
    end

    // Odd parity, 0x01 has one '1' so expected parity bit is 0; send 1
    send_frame(8'h01, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    check("pe_pulse", 32'(bus.par_err),     32'h1);
    check("pe_cnt",   32'(bus.par_err_cnt), 32'h1);
    check("pe_valid", 32'(bus.data_valid),  32'h0);
    check("pe_data",  32'(bus.data_out),    32'hA5);
    check("pe_stp",   32'(bus.stp_err),     32'h0);

    // Two stop bits, no parity
    send_frame(8'h3C, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    check("ts_valid", 32'(bus.data_valid), 32'h1);
    check("ts_data",  32'(bus.data_out),   32'h3C);
    check("ts_stp",   32'(bus.stp_err),    32'h0);
    send_frame(8'h3C, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    check("se_pulse", 32'(bus.stp_err),     32'h1);
    check("se_cnt",   32'(bus.stp_err_cnt), 32'h1);
    check("se_valid", 32'(bus.data_valid),  32'h0);
    check("se_par",   32'(bus.par_err),     32'h0);

    // Clear all counters
    @(negedge clk);
    bus.clr_cnt = 1'b1;
    @(negedge clk);
    bus.clr_cnt = 1'b0;
    check("clr_gcnt", 32'(bus.glitch_cnt),  32'h0);
    check("clr_pcnt", 32'(bus.par_err_cnt), 32'h0);
    check("clr_scnt", 32'(bus.stp_err_cnt), 32'h0);

    // Five glitches saturate the 2-bit counter at 3; first one also has a coincident strobe
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      bus.frame_begin = 1'b1;
      bus.bit_valid   = (i == 0);
      bus.sampled_bit = 1'b1;
      @(negedge clk);
      bus.frame_begin = 1'b0;
      bus.bit_valid   = 1'b0;
      check("sat_started", 32'(bus.strt_glitch), 32'h0);
      send_bit(1'b1, 1'b0);
      check("sat_pulse", 32'(bus.strt_glitch), 32'h1);
      check("sat_cnt",   32'(bus.glitch_cnt),  (i < 3) ? 32'(i + 1) : 32'h3);
    end
    begin_frame(1'b0, 1'b0, 1'b0);
    send_bit(1'b1, 1'b1);
    check("clrpri_pulse", 32'(bus.strt_glitch), 32'h1);
    check("clrpri_cnt",   32'(bus.glitch_cnt),  32'h0);

    // Reset after four data bits of 0x5A
    begin_frame(1'b0, 1'b0, 1'b0);
    send_bit(1'b0, 1'b0);
    for (int i = 0; i < 4; i++) send_bit(d5a[i], 1'b0);
    check("mid_busy", 32'(bus.busy), 32'h1);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_idle_zero("midrst");
    @(negedge clk);
    rst = 1'b1;
    send_frame(8'h5A, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    check("post_valid", 32'(bus.data_valid), 32'h1);
    check("post_data",  32'(bus.data_out),   32'h5A);
    check("post_err",   32'({bus.par_err, bus.stp_err}), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
